tex_dcr_dump: RTL and testbench
===============================

Name: tex_dcr_dump

Overview:
- Read-back engine for texture DCR state, and the reader counterpart of the texture DCR write path that fills tex_dcrs_t per stage.
- On a host/debug read request for one texture stage, it snapshots that stage's tex_dcrs_t and streams it out as a fixed sequence of WORD_BITS-wide words over a valid/ready response channel.
- Sits beside the texture DCR register file inside the tex unit and feeds the DCR read/debug bus.

Parameters:
- NUM_STAGES, 2, number of texture stages; selects which tex_dcrs_t entry is read.
- WORD_BITS, 32, response word width.
- TAG_BITS, 4, request tag width; the tag is echoed on every response word.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- dcrs  in  NUM_STAGES x tex_dcrs_t  live DCR state, one entry per stage.
- req_valid  in  1  read request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_stage  in  max(1,$clog2(NUM_STAGES))  stage to dump.
- req_tag  in  TAG_BITS  request tag.
- rsp_valid  out  1  response word valid.
- rsp_ready  in  1  downstream accepts the word.
- rsp_data  out  WORD_BITS  response word.
- rsp_idx  out  $clog2(N_WORDS)  word index within the dump.
- rsp_last  out  1  final word of the dump.
- rsp_err  out  1  request named a nonexistent stage.
- rsp_tag  out  TAG_BITS  echoed req_tag.

Behaviour:
- N_WORDS = TEX_LOD_MAX + 3.
  - Word 0 is the header. From bit 0 upward it packs: format, filter, wraps[0], wraps[1], logdims[0], logdims[1]. Remaining bits are zero.
  - Word 1 is baddr, zero-extended.
  - Words 2..N_WORDS-1 are mipoff[0..TEX_LOD_MAX], each zero-extended.
- Elaboration-time checks: the header field width sum must be ≤ WORD_BITS; TEX_ADDR_BITS ≤ WORD_BITS; TEX_MIPOFF_BITS ≤ WORD_BITS.
- State machine IDLE/STREAM:
  - IDLE: req_ready=1 and rsp_valid=0.
    - On request accept, latch dcrs[req_stage] into the snapshot register, latch the tag, set idx=0, go to STREAM.
    - rsp_valid rises the cycle after accept, so first-word latency is 1 cycle.
  - STREAM: req_ready=0 and rsp_valid=1. rsp_data is muxed from the snapshot by idx. rsp_last = (idx == N_WORDS-1).
    - On rsp_valid && rsp_ready with rsp_last=0: idx increments.
    - On rsp_valid && rsp_ready with rsp_last=1: return to IDLE. The next request can be accepted in the cycle after the last handshake, with no overlap.
- Snapshot semantics: DCR writes to dcrs during STREAM do not affect the words being streamed. The dump reflects dcrs exactly as sampled on the accept cycle.
- Backpressure: while rsp_valid=1 && rsp_ready=0, all rsp_* outputs hold stable. idx never skips and never repeats.
- Invalid stage (req_stage ≥ NUM_STAGES, possible when NUM_STAGES is not a power of 2):
  - Emit a single word: rsp_data=0, rsp_idx=0, rsp_last=1, rsp_err=1.
  - After its handshake, return to IDLE.
  - rsp_err=0 on every valid dump word.
- Reset (asserting at any time, including mid-dump) drops to IDLE immediately; the dump is abandoned and nothing resumes. Reset values of all state, registered outputs and snapshot are 0: rsp_valid=0, rsp_data=0, rsp_idx=0, rsp_last=0, rsp_err=0, rsp_tag=0. req_ready reads 1 once reset_n deasserts.
- rsp_ready asserted while in IDLE is ignored.

Optional Feature:
- Macro: TEX_DCR_DUMP_PARITY_EN.
- Defined:
  - Adds output port rsp_parity (1 bit) = even parity (XOR reduction) of rsp_data, registered alongside rsp_data.
  - rsp_parity is 0 at reset, and is also 0 on the error word.
- Undefined: the port is absent and the behaviour is otherwise identical.

Decomposition:
- Shared package (extend the tex_types package):
  - TEX_DCR_DUMP_WORDS constant (= TEX_LOD_MAX+3).
  - tex_dcr_hdr_t packed struct for the header field order.
  - Enum tex_dcr_dump_state_t {IDLE, STREAM}.
- One natural sub-module, tex_dcr_pack: a combinational function of (snapshot, idx) → WORD_BITS word. Keep it separate so the verifier can reuse it as the reference model.

Test Plan:
- Basic dump, rsp_ready=1 throughout:
  - Stimulus: stage 1 with format=2, filter=1, wraps={1,2}, logdims={3,4}, baddr=0x1000, mipoff[i]=i*0x40.
  - Response: N_WORDS words on consecutive cycles, idx 0..N_WORDS-1, last=1 only on the final word, tag echoed, word 1=0x1000, word 2+i = i*0x40.
- Snapshot isolation: change dcrs[1].baddr to 0xDEAD0 one cycle after accept → word 1 still reads 0x1000.
- Backpressure: toggle rsp_ready 1,0,0,1 pseudo-randomly → outputs stable while stalled; no index skipped or repeated; req_ready=0 until the cycle after the last handshake.
- Invalid stage: NUM_STAGES=3, req_stage=3, tag=5 → exactly one word with data=0, last=1, err=1, tag=5, then req_ready=1.
- Reset mid-dump: pull reset_n low at idx=4 → rsp_valid=0 and req_ready=0 during reset; req_ready=1 after release; a new request for stage 0 starts at idx=0.
- With TEX_DCR_DUMP_PARITY_EN: baddr=0x7 → rsp_parity=1 on word 1; baddr=0x3 → rsp_parity=0.

Source files
------------

// File: rtl/tex_dcr_dump_pkg.sv
// Shared texture DCR types plus the read-back (dump) additions.
//   tex_dcrs_t            per-stage texture DCR state (written by the DCR write path)
//   tex_dcr_hdr_t         header word field order, format at bit 0 upward
//   TEX_DCR_DUMP_WORDS    words per dump: header, baddr, mipoff[0..TEX_LOD_MAX]
//   tex_dcr_dump_state_t  dump engine states
package tex_dcr_dump_pkg;

  localparam int TEX_LOD_MAX     = 11;
  localparam int TEX_FORMAT_BITS = 3;
  localparam int TEX_FILTER_BITS = 2;
  localparam int TEX_WRAP_BITS   = 2;
  localparam int TEX_LOD_BITS    = 4;
  localparam int TEX_ADDR_BITS   = 32;
  localparam int TEX_MIPOFF_BITS = 20;

  typedef struct packed {
    logic [TEX_FORMAT_BITS-1:0]                 format;
    logic [TEX_FILTER_BITS-1:0]                 filter;
    logic [1:0][TEX_WRAP_BITS-1:0]              wraps;
    logic [1:0][TEX_LOD_BITS-1:0]               logdims;
    logic [TEX_ADDR_BITS-1:0]                   baddr;
    logic [TEX_LOD_MAX:0][TEX_MIPOFF_BITS-1:0]  mipoff;
  } tex_dcrs_t;

  // Packed structs fill from the MSB, so the list runs last-field-first.
  typedef struct packed {
    logic [TEX_LOD_BITS-1:0]    logdims1;
    logic [TEX_LOD_BITS-1:0]    logdims0;
    logic [TEX_WRAP_BITS-1:0]   wraps1;
    logic [TEX_WRAP_BITS-1:0]   wraps0;
    logic [TEX_FILTER_BITS-1:0] filter;
    logic [TEX_FORMAT_BITS-1:0] format;
  } tex_dcr_hdr_t;

  localparam int TEX_DCR_HDR_BITS   = $bits(tex_dcr_hdr_t);
  localparam int TEX_DCR_DUMP_WORDS = TEX_LOD_MAX + 3;
  localparam int TEX_DCR_IDX_BITS   = $clog2(TEX_DCR_DUMP_WORDS);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } tex_dcr_dump_state_t;

  function automatic tex_dcr_hdr_t tex_dcr_hdr(input tex_dcrs_t d);
    tex_dcr_hdr_t h;
    h.format   = d.format;
    h.filter   = d.filter;
    h.wraps0   = d.wraps[0];
    h.wraps1   = d.wraps[1];
    h.logdims0 = d.logdims[0];
    h.logdims1 = d.logdims[1];
    return h;
  endfunction

endpackage

// File: rtl/tex_dcr_dump_if.sv
// Request/response channel of the texture DCR dump engine.
//   req_*  : requester -> engine read request (valid/ready)
//   rsp_*  : engine -> consumer word stream (valid/ready)
//   rsp_parity exists only when TEX_DCR_DUMP_PARITY_EN is defined.
// Modports: master = requester/consumer side, slave = dump engine.
interface tex_dcr_dump_if #(
  parameter int STAGE_BITS = 1,
  parameter int TAG_BITS   = 4,
  parameter int WORD_BITS  = 32,
  parameter int IDX_BITS   = tex_dcr_dump_pkg::TEX_DCR_IDX_BITS
);
  logic                  req_valid;
  logic                  req_ready;
  logic [STAGE_BITS-1:0] req_stage;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WORD_BITS-1:0]  rsp_data;
  logic [IDX_BITS-1:0]   rsp_idx;
  logic                  rsp_last;
  logic                  rsp_err;
  logic [TAG_BITS-1:0]   rsp_tag;
`ifdef TEX_DCR_DUMP_PARITY_EN
  logic                  rsp_parity;
`endif

  modport master (
    output req_valid, req_stage, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_idx, rsp_last, rsp_err, rsp_tag
`ifdef TEX_DCR_DUMP_PARITY_EN
    , input rsp_parity
`endif
  );

  modport slave (
    input  req_valid, req_stage, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_idx, rsp_last, rsp_err, rsp_tag
`ifdef TEX_DCR_DUMP_PARITY_EN
    , output rsp_parity
`endif
  );
endinterface

// File: rtl/tex_dcr_pack.sv
// Combinational word selector for a DCR dump.
//   dcrs : stage snapshot
//   idx  : word index (0 header, 1 baddr, 2.. mipoff[idx-2])
//   word : WORD_BITS-wide zero-extended word
module tex_dcr_pack
  import tex_dcr_dump_pkg::*;
#(
  parameter int WORD_BITS = 32
) (
  input  tex_dcrs_t                   dcrs,
  input  logic [TEX_DCR_IDX_BITS-1:0] idx,
  output logic [WORD_BITS-1:0]        word
);
  always_comb begin
    word = '0;
    if (idx == '0)
      word[TEX_DCR_HDR_BITS-1:0] = tex_dcr_hdr(dcrs);
    else if (idx == TEX_DCR_IDX_BITS'(1))
      word[TEX_ADDR_BITS-1:0] = dcrs.baddr;
    for (int unsigned i = 0; i <= TEX_LOD_MAX; i++) begin
      if (idx == TEX_DCR_IDX_BITS'(i + 2))
        word[TEX_MIPOFF_BITS-1:0] = dcrs.mipoff[i];
    end
  end
endmodule

// File: rtl/tex_dcr_dump.sv
// Texture DCR read-back engine. On an accepted request it snapshots
// dcrs[req_stage] and streams TEX_DCR_DUMP_WORDS words, echoing the tag.
// A request for a nonexistent stage yields one zero word with rsp_err=1.
//   clk, reset_n : clock, async active-low reset
//   dcrs         : live DCR state, one entry per stage
//   bus          : tex_dcr_dump_if slave (req_* in, rsp_* out)
// Optional: TEX_DCR_DUMP_PARITY_EN adds bus.rsp_parity (XOR of rsp_data).
module tex_dcr_dump
  import tex_dcr_dump_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int WORD_BITS  = 32,
  parameter int TAG_BITS   = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  tex_dcrs_t      dcrs [NUM_STAGES],
  tex_dcr_dump_if.slave  bus
);
  localparam int STAGE_BITS = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [TEX_DCR_IDX_BITS-1:0] LAST_IDX = TEX_DCR_IDX_BITS'(TEX_DCR_DUMP_WORDS - 1);
  localparam logic [STAGE_BITS:0] STAGE_LIMIT = (STAGE_BITS + 1)'(NUM_STAGES);

  if (TEX_DCR_HDR_BITS > WORD_BITS) begin : g_hdr_chk
    $error("tex_dcr_dump: header wider than WORD_BITS");
  end
  if (TEX_ADDR_BITS > WORD_BITS) begin : g_addr_chk
    $error("tex_dcr_dump: TEX_ADDR_BITS wider than WORD_BITS");
  end
  if (TEX_MIPOFF_BITS > WORD_BITS) begin : g_mip_chk
    $error("tex_dcr_dump: TEX_MIPOFF_BITS wider than WORD_BITS");
  end

  tex_dcr_dump_state_t         state;
  tex_dcrs_t                   snap;
  logic                        ready_q, valid_q, last_q, err_q;
  logic [WORD_BITS-1:0]        data_q;
  logic [TEX_DCR_IDX_BITS-1:0] idx_q;
  logic [TAG_BITS-1:0]         tag_q;

  logic                        accept, hs, stage_ok;
  tex_dcrs_t                   sel_dcrs, pack_src;
  logic [TEX_DCR_IDX_BITS-1:0] pack_idx;
  logic [WORD_BITS-1:0]        pack_word, load_word;

  assign accept   = ready_q && bus.req_valid;
  assign hs       = valid_q && bus.rsp_ready;
  assign stage_ok = {1'b0, bus.req_stage} < STAGE_LIMIT;

  always_comb begin
    sel_dcrs = '0;
    if (stage_ok) sel_dcrs = dcrs[bus.req_stage];
  end

  // One packer serves both cases: the first word straight from the live
  // entry on accept, every later word from the snapshot at idx+1.
  assign pack_src = accept ? sel_dcrs : snap;
  assign pack_idx = accept ? '0 : idx_q + TEX_DCR_IDX_BITS'(1);

  tex_dcr_pack #(.WORD_BITS(WORD_BITS)) u_pack (
    .dcrs (pack_src),
    .idx  (pack_idx),
    .word (pack_word)
  );

  assign load_word = (accept && !stage_ok) ? '0 : pack_word;

`ifdef TEX_DCR_DUMP_PARITY_EN
  logic parity_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    parity_q <= 1'b0;
    else if (accept || (hs && !last_q)) parity_q <= ^load_word;
  end
  assign bus.rsp_parity = parity_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      snap    <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      tag_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready_q <= !accept;
          if (accept) begin
            state   <= STREAM;
            valid_q <= 1'b1;
            snap    <= sel_dcrs;
            tag_q   <= bus.req_tag;
            idx_q   <= '0;
            last_q  <= !stage_ok;
            err_q   <= !stage_ok;
            data_q  <= load_word;
          end
        end
        STREAM: begin
          if (hs) begin
            if (last_q) begin
              state   <= IDLE;
              valid_q <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              idx_q  <= pack_idx;
              last_q <= (pack_idx == LAST_IDX);
              data_q <= load_word;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_idx   = idx_q;
  assign bus.rsp_last  = last_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_tag   = tag_q;
endmodule

// File: tb/tb_tex_dcr_dump.sv
module tb_tex_dcr_dump;
  import tex_dcr_dump_pkg::*;

  localparam int NW = TEX_DCR_DUMP_WORDS;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  tex_dcrs_t dcrs_a [2];
  tex_dcrs_t dcrs_b [3];

  tex_dcr_dump_if #(.STAGE_BITS(1), .TAG_BITS(4), .WORD_BITS(32), .IDX_BITS(TEX_DCR_IDX_BITS)) ia ();
  tex_dcr_dump_if #(.STAGE_BITS(2), .TAG_BITS(4), .WORD_BITS(32), .IDX_BITS(TEX_DCR_IDX_BITS)) ib ();

  tex_dcr_dump #(.NUM_STAGES(2), .WORD_BITS(32), .TAG_BITS(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .dcrs(dcrs_a), .bus(ia.slave));
  tex_dcr_dump #(.NUM_STAGES(3), .WORD_BITS(32), .TAG_BITS(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .dcrs(dcrs_b), .bus(ib.slave));

  typedef struct {
    logic [31:0] data;
    logic [TEX_DCR_IDX_BITS-1:0] idx;
    logic last;
    logic err;
    logic [3:0] tag;
  } exp_t;

  typedef struct {
    logic v, rr, last, err, par;
    logic [31:0] data;
    logic [TEX_DCR_IDX_BITS-1:0] idx;
    logic [3:0] tag;
  } obs_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  function automatic logic [31:0] model_word(input tex_dcrs_t d, input int w);
    if (w == 0)
      return 32'(d.format) | (32'(d.filter) << 3) | (32'(d.wraps[0]) << 5) |
             (32'(d.wraps[1]) << 7) | (32'(d.logdims[0]) << 9) | (32'(d.logdims[1]) << 13);
    if (w == 1) return d.baddr;
    return 32'(d.mipoff[w-2]);
  endfunction

  function automatic void push_dump(input tex_dcrs_t d, input logic [3:0] tag);
    exp_t e;
    for (int w = 0; w < NW; w++) begin
      e.data = model_word(d, w);
      e.idx  = TEX_DCR_IDX_BITS'(w);
      e.last = (w == NW - 1);
      e.err  = 1'b0;
      e.tag  = tag;
      exp_q.push_back(e);
    end
  endfunction

  function automatic obs_t sample(input int which);
    obs_t o;
    o.par = 1'b0;
    if (which == 0) begin
      o.v = ia.rsp_valid; o.rr = ia.req_ready; o.data = ia.rsp_data; o.idx = ia.rsp_idx;
      o.last = ia.rsp_last; o.err = ia.rsp_err; o.tag = ia.rsp_tag;
`ifdef TEX_DCR_DUMP_PARITY_EN
      o.par = ia.rsp_parity;
`endif
    end else begin
      o.v = ib.rsp_valid; o.rr = ib.req_ready; o.data = ib.rsp_data; o.idx = ib.rsp_idx;
      o.last = ib.rsp_last; o.err = ib.rsp_err; o.tag = ib.rsp_tag;
`ifdef TEX_DCR_DUMP_PARITY_EN
      o.par = ib.rsp_parity;
`endif
    end
    return o;
  endfunction

  task automatic set_rr(input int which, input logic v);
    if (which == 0) ia.rsp_ready = v; else ib.rsp_ready = v;
  endtask

  // Present a request and return at posedge+1 of the accepting edge.
  task automatic issue(input int which, input logic [1:0] stage, input logic [3:0] tag);
    bit ok = 0;
    @(posedge clk); #1;
    if (which == 0) begin ia.req_valid = 1'b1; ia.req_stage = stage[0:0]; ia.req_tag = tag; end
    else begin ib.req_valid = 1'b1; ib.req_stage = stage; ib.req_tag = tag; end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sample(which).rr) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    if (which == 0) ia.req_valid = 1'b0; else ib.req_valid = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL issue_timeout: req_ready never 1 (required 1)"); end
  endtask

  // Consume one dump against the scoreboard; bp selects backpressure.
  task automatic drain(input int which, input bit bp, input int maxcyc, output int ncyc);
    logic pat [4];
    bit done = 0, have_prev = 0;
    logic rdy;
    obs_t o, prev;
    exp_t e;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    ncyc = 0;
    for (int c = 0; c < maxcyc && !done; c++) begin
      rdy = !bp ? 1'b1 : (c < 8) ? pat[c % 4] : 1'($urandom_range(0, 1));
      set_rr(which, rdy);
      @(negedge clk);
      o = sample(which);
      ncyc++;
      total++;
      if (o.v !== 1'b1) begin bad++; $display("FAIL rsp_valid_stream: got %b want 1", o.v); end
      total++;
      if (o.rr !== 1'b0) begin bad++; $display("FAIL req_ready_busy: got %b want 0", o.rr); end
      if (have_prev) begin
        total++;
        if (o.data !== prev.data || o.idx !== prev.idx || o.last !== prev.last ||
            o.err !== prev.err || o.tag !== prev.tag || o.par !== prev.par) begin
          bad++;
          $display("FAIL stall_hold: got d=%h i=%0d l=%b e=%b t=%h want d=%h i=%0d l=%b e=%b t=%h",
                   o.data, o.idx, o.last, o.err, o.tag, prev.data, prev.idx, prev.last, prev.err, prev.tag);
        end
        have_prev = 0;
      end
      if (o.v && rdy) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL sb_extra: got word idx=%0d want none", o.idx);
          done = 1;
        end else begin
          e = exp_q.pop_front();
          if (o.data !== e.data || o.idx !== e.idx || o.last !== e.last ||
              o.err !== e.err || o.tag !== e.tag) begin
            bad++;
            $display("FAIL sb_word: got d=%h i=%0d l=%b e=%b t=%h want d=%h i=%0d l=%b e=%b t=%h",
                     o.data, o.idx, o.last, o.err, o.tag, e.data, e.idx, e.last, e.err, e.tag);
          end
`ifdef TEX_DCR_DUMP_PARITY_EN
          total++;
          if (o.par !== ^e.data) begin
            bad++; $display("FAIL sb_parity: got %b want %b", o.par, ^e.data);
          end
`endif
          if (o.last) done = 1;
        end
      end else if (o.v) begin
        prev = o; have_prev = 1;
      end
      @(posedge clk); #1;
    end
    total++;
    if (!done) begin bad++; $display("FAIL drain_timeout: last not seen in %0d cycles", maxcyc); end
    @(negedge clk);
    o = sample(which);
    total++;
    if (o.v !== 1'b0 || o.rr !== 1'b1) begin
      bad++; $display("FAIL after_last: got valid=%b ready=%b want valid=0 ready=1", o.v, o.rr);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_left: got %0d words pending want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset;
    obs_t o;
    @(negedge clk);
    o = sample(0);
    total++;
    if (o.v !== 0 || o.rr !== 0 || o.data !== 0 || o.idx !== 0 || o.last !== 0 ||
        o.err !== 0 || o.tag !== 0 || o.par !== 0) begin
      bad++;
      $display("FAIL reset_vals: got v=%b rr=%b d=%h i=%0d l=%b e=%b t=%h p=%b want all 0",
               o.v, o.rr, o.data, o.idx, o.last, o.err, o.tag, o.par);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    set_rr(0, 1'b1);  // ignored while idle
    @(negedge clk);
    o = sample(0);
    total++;
    if (o.rr !== 1'b1 || o.v !== 1'b0) begin
      bad++; $display("FAIL reset_release: got rr=%b v=%b want rr=1 v=0", o.rr, o.v);
    end
    set_rr(0, 1'b0);
  endtask

  task automatic test_basic;
    int n;
    push_dump(dcrs_a[1], 4'h9);
    issue(0, 2'd1, 4'h9);
    drain(0, 1'b0, 40, n);
    total++;
    if (n != NW) begin bad++; $display("FAIL basic_cycles: got %0d want %0d", n, NW); end
  endtask

  task automatic test_snapshot;
    int n;
    push_dump(dcrs_a[1], 4'h3);
    issue(0, 2'd1, 4'h3);
    dcrs_a[1].baddr = 32'hDEAD0;
    drain(0, 1'b0, 40, n);
  endtask

  task automatic test_back_to_back;
    int n;
    push_dump(dcrs_a[0], 4'hA);
    issue(0, 2'd0, 4'hA);
    drain(0, 1'b1, 200, n);
    total++;
    if (n <= NW) begin bad++; $display("FAIL bp_cycles: got %0d want >%0d", n, NW); end
    push_dump(dcrs_a[1], 4'hB);
    issue(0, 2'd1, 4'hB);
    drain(0, 1'b1, 200, n);
  endtask

  task automatic test_invalid_stage;
    int n;
    exp_t e;
    e.data = 32'h0; e.idx = '0; e.last = 1'b1; e.err = 1'b1; e.tag = 4'h5;
    exp_q.push_back(e);
    issue(1, 2'd3, 4'h5);
    drain(1, 1'b0, 10, n);
    total++;
    if (n != 1) begin bad++; $display("FAIL invalid_count: got %0d want 1", n); end
  endtask

  task automatic test_reset_mid;
    obs_t o;
    bit hit = 0;
    int n;
    push_dump(dcrs_a[0], 4'h7);
    issue(0, 2'd0, 4'h7);
    set_rr(0, 1'b1);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      o = sample(0);
      if (o.v && o.idx == TEX_DCR_IDX_BITS'(4)) begin hit = 1; break; end
    end
    total++;
    if (!hit) begin bad++; $display("FAIL mid_reach: idx 4 not seen want seen"); end
    reset_n = 1'b0;
    exp_q.delete();
    set_rr(0, 1'b0);
    #1;
    o = sample(0);
    total++;
    if (o.v !== 1'b0 || o.rr !== 1'b0 || o.idx !== '0) begin
      bad++; $display("FAIL mid_reset: got v=%b rr=%b i=%0d want 0 0 0", o.v, o.rr, o.idx);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    o = sample(0);
    total++;
    if (o.v !== 1'b0 || o.rr !== 1'b0) begin
      bad++; $display("FAIL mid_hold: got v=%b rr=%b want 0 0", o.v, o.rr);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    o = sample(0);
    total++;
    if (o.rr !== 1'b1 || o.v !== 1'b0) begin
      bad++; $display("FAIL mid_release: got rr=%b v=%b want 1 0", o.rr, o.v);
    end
    push_dump(dcrs_a[0], 4'h2);
    issue(0, 2'd0, 4'h2);
    drain(0, 1'b0, 40, n);
  endtask

`ifdef TEX_DCR_DUMP_PARITY_EN
  task automatic test_parity;
    int n;
    dcrs_a[0].baddr = 32'h7;
    push_dump(dcrs_a[0], 4'h1);
    issue(0, 2'd0, 4'h1);
    drain(0, 1'b0, 40, n);
    dcrs_a[0].baddr = 32'h3;
    push_dump(dcrs_a[0], 4'h1);
    issue(0, 2'd0, 4'h1);
    drain(0, 1'b0, 40, n);
  endtask
`endif

  initial begin
    for (int s = 0; s < 2; s++) dcrs_a[s] = '0;
    for (int s = 0; s < 3; s++) dcrs_b[s] = '0;
    dcrs_a[1].format = 3'd2;  dcrs_a[1].filter = 2'd1;
    dcrs_a[1].wraps[0] = 2'd1; dcrs_a[1].wraps[1] = 2'd2;
    dcrs_a[1].logdims[0] = 4'd3; dcrs_a[1].logdims[1] = 4'd4;
    dcrs_a[1].baddr = 32'h1000;
    dcrs_a[0].format = 3'd5;  dcrs_a[0].filter = 2'd2;
    dcrs_a[0].wraps[0] = 2'd3; dcrs_a[0].wraps[1] = 2'd0;
    dcrs_a[0].logdims[0] = 4'hF; dcrs_a[0].logdims[1] = 4'd1;
    dcrs_a[0].baddr = 32'hCAFE0000;
    for (int i = 0; i <= TEX_LOD_MAX; i++) begin
      dcrs_a[1].mipoff[i] = TEX_MIPOFF_BITS'(i * 32'h40);
      dcrs_a[0].mipoff[i] = TEX_MIPOFF_BITS'(i * 32'h111 + 7);
      dcrs_b[2].mipoff[i] = TEX_MIPOFF_BITS'(i + 1);
    end
    ia.req_valid = 1'b0; ia.req_stage = '0; ia.req_tag = '0; ia.rsp_ready = 1'b0;
    ib.req_valid = 1'b0; ib.req_stage = '0; ib.req_tag = '0; ib.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_basic();
    test_snapshot();
    test_back_to_back();
    test_invalid_stage();
    test_reset_mid();
`ifdef TEX_DCR_DUMP_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
